// File: rtl/act_relu_quant.sv
// Activation stage feeding the 2x2 pooler: per-channel bias add, ReLU, round-half-up right shift,
// saturate to DATA_WIDTH. Fixed 3-stage pipeline, no back-pressure.
module act_relu_quant #(
  parameter int unsigned ACC_WIDTH  = 32,
  parameter int unsigned DATA_WIDTH = 8,
  parameter int unsigned MAX_CH     = 16,
  localparam int unsigned CW        = $clog2(MAX_CH)
) (
  input  logic                  clk,
  input  logic                  rst,
  input  logic                  cfg_we_i,
  input  logic [CW-1:0]         cfg_addr_i,
  input  logic [ACC_WIDTH-1:0]  cfg_bias_i,
  input  logic                  start_i,
  input  logic [4:0]            cfg_shift_i,
  input  logic [CW:0]           cfg_ch_num_i,
  input  logic                  acc_valid_i,
  input  logic                  acc_last_i,
  input  logic [ACC_WIDTH-1:0]  acc_data_i,
  output logic                  act_valid_o,
  output logic                  act_last_o,
  output logic [DATA_WIDTH-1:0] act_result_o,
  output logic                  busy_o
);

  typedef enum logic [1:0] {StIdle, StRun, StDrain} state_e;

  state_e               state_q, state_d;
  logic [CW-1:0]        ch_idx_q, ch_idx_d;
  logic [CW:0]          ch_num_q, ch_num_clamped;
  logic [4:0]           shift_q;
  logic [ACC_WIDTH-1:0] bias_q [MAX_CH];

  logic                 accept, cfg_take, start_take;
  logic [2:0]           vld_q, lst_q;
  logic [ACC_WIDTH:0]   s1_q, s2_q, s1_d, relu, rnd, quant;
  logic [DATA_WIDTH-1:0] res_q, sat;

  always_comb begin
    if (cfg_ch_num_i == '0) begin
      ch_num_clamped = (CW+1)'(1);
    end else if (cfg_ch_num_i > (CW+1)'(MAX_CH)) begin
      ch_num_clamped = (CW+1)'(MAX_CH);
    end else begin
      ch_num_clamped = cfg_ch_num_i;
    end
  end

  always_comb begin
    state_d    = state_q;
    ch_idx_d   = ch_idx_q;
    accept     = 1'b0;
    cfg_take   = 1'b0;
    start_take = 1'b0;
    unique case (state_q)
      StIdle: begin
        cfg_take = cfg_we_i;
        if (start_i) begin
          start_take = 1'b1;
          ch_idx_d   = '0;
          state_d    = StRun;
        end
      end
      StRun: begin
        if (acc_valid_i) begin
          accept = 1'b1;
          if (acc_last_i) begin
            state_d  = StDrain;
            ch_idx_d = '0;
          end else if ({1'b0, ch_idx_q} == ch_num_q - (CW+1)'(1)) begin
            ch_idx_d = '0;
          end else begin
            ch_idx_d = ch_idx_q + CW'(1);
          end
        end
      end
      StDrain: begin
        // Leave once the final activation is on the outputs.
        if (lst_q[2]) state_d = StIdle;
      end
      default: state_d = StIdle;
    endcase
  end

  // Sign-extended add cannot overflow in ACC_WIDTH+1 bits.
  assign s1_d = {acc_data_i[ACC_WIDTH-1], acc_data_i}
              + {bias_q[ch_idx_q][ACC_WIDTH-1], bias_q[ch_idx_q]};

  always_comb begin
    relu  = s1_q[ACC_WIDTH] ? '0 : s1_q;
    rnd   = (shift_q == 5'd0) ? '0 : ((ACC_WIDTH+1)'(1) << (shift_q - 5'd1));
    quant = (relu + rnd) >> shift_q;
  end

  assign sat = (|s2_q[ACC_WIDTH:DATA_WIDTH]) ? '1 : s2_q[DATA_WIDTH-1:0];

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q  <= StIdle;
      ch_idx_q <= '0;
      ch_num_q <= (CW+1)'(1);
      shift_q  <= '0;
      for (int i = 0; i < MAX_CH; i++) bias_q[i] <= '0;
      vld_q    <= '0;
      lst_q    <= '0;
      s1_q     <= '0;
      s2_q     <= '0;
      res_q    <= '0;
    end else begin
      state_q  <= state_d;
      ch_idx_q <= ch_idx_d;
      if (cfg_take) bias_q[cfg_addr_i] <= cfg_bias_i;
      if (start_take) begin
        shift_q  <= cfg_shift_i;
        ch_num_q <= ch_num_clamped;
      end
      vld_q <= {vld_q[1:0], accept};
      lst_q <= {lst_q[1:0], accept & acc_last_i};
      if (accept)   s1_q  <= s1_d;
      if (vld_q[0]) s2_q  <= quant;
      if (vld_q[1]) res_q <= sat;
    end
  end

  assign act_valid_o  = vld_q[2];
  assign act_last_o   = lst_q[2];
  assign act_result_o = res_q;
  assign busy_o       = (state_q != StIdle);

endmodule

// File: tb/tb_act_relu_quant.sv
// Self-checking bench for act_relu_quant: directed vector table, illegal-config and reset
// sequences, and randomized layers scored against an arithmetic reference model.
module tb_act_relu_quant;
  localparam int AW = 32;
  localparam int CW = 4;

  logic          clk = 1'b0;
  logic          rst = 1'b0;
  logic          cfg_we_i = 1'b0;
  logic [CW-1:0] cfg_addr_i = '0;
  logic [AW-1:0] cfg_bias_i = '0;
  logic          start_i = 1'b0;
  logic [4:0]    cfg_shift_i = '0;
  logic [CW:0]   cfg_ch_num_i = '0;
  logic          acc_valid_i = 1'b0;
  logic          acc_last_i = 1'b0;
  logic [AW-1:0] acc_data_i = '0;
  logic          act_valid_o, act_last_o, busy_o;
  logic [7:0]    act_result_o;

  act_relu_quant dut (
    .clk          (clk),
    .rst          (rst),
    .cfg_we_i     (cfg_we_i),
    .cfg_addr_i   (cfg_addr_i),
    .cfg_bias_i   (cfg_bias_i),
    .start_i      (start_i),
    .cfg_shift_i  (cfg_shift_i),
    .cfg_ch_num_i (cfg_ch_num_i),
    .acc_valid_i  (acc_valid_i),
    .acc_last_i   (acc_last_i),
    .acc_data_i   (acc_data_i),
    .act_valid_o  (act_valid_o),
    .act_last_o   (act_last_o),
    .act_result_o (act_result_o),
    .busy_o       (busy_o)
  );

  always #5 clk = ~clk;

  typedef struct packed {logic last; logic [7:0] res;} exp_t;
  typedef struct {int grp; int acc; logic last; logic [7:0] exp;} vec_t;

  int         n_cmp = 0;
  int         n_err = 0;
  int         edge_cnt = 0;
  int         last_edge = 0;
  bit         chk_en = 1'b0;
  logic [7:0] last_res = 8'd0;
  exp_t       exp_map [int];
  int         bias_m [16];
  vec_t       tab [16];

  always @(posedge clk) edge_cnt <= edge_cnt + 1;

  task automatic chk(input string name, input logic [63:0] act, input logic [63:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_err++;
      $display("FAIL %s: got %0d, expected %0d (edge %0d)", name, act, exp, edge_cnt);
    end
  endtask

  // Output scoreboard: anything not scheduled must be a bubble with the result held.
  always @(negedge clk) begin
    if (chk_en) begin
      if (exp_map.exists(edge_cnt)) begin
        chk("act_valid", act_valid_o, 1);
        chk("act_last", act_last_o, exp_map[edge_cnt].last);
        chk("act_result", act_result_o, exp_map[edge_cnt].res);
        last_res = exp_map[edge_cnt].res;
        exp_map.delete(edge_cnt);
      end else begin
        chk("bubble_valid", act_valid_o, 0);
        chk("bubble_last", act_last_o, 0);
        chk("result_hold", act_result_o, last_res);
      end
    end
  end

  function automatic logic [7:0] ref_act(input int acc, input int b, input int sh);
    longint s, q;
    s = longint'(acc) + longint'(b);
    if (s < 0) s = 0;
    q = (sh == 0) ? s : ((s + (longint'(1) << (sh - 1))) >> sh);
    return (q > 255) ? 8'd255 : 8'(q);
  endfunction

  // All tasks start and end 1 time unit after a rising edge.
  task automatic drive(input logic v, input logic l, input int d, input bit take,
                       input logic [7:0] e);
    acc_valid_i = v;
    acc_last_i  = l;
    acc_data_i  = d;
    if (take) begin
      exp_map[edge_cnt + 3] = '{l, e};
      if (l) last_edge = edge_cnt;
    end
    @(posedge clk); #1;
  endtask

  task automatic write_bias(input int a, input int b);
    cfg_we_i = 1'b1; cfg_addr_i = CW'(a); cfg_bias_i = b;
    bias_m[a] = b;
    @(posedge clk); #1;
    cfg_we_i = 1'b0;
  endtask

  task automatic start(input int sh, input int ch);
    start_i = 1'b1; cfg_shift_i = 5'(sh); cfg_ch_num_i = 5'(ch);
    @(posedge clk); #1;
    start_i = 1'b0; acc_valid_i = 1'b0;
    chk("busy_rise", busy_o, 1);
  endtask

  // Keeps valid high through drain; none of it may reach the outputs.
  task automatic end_layer();
    int k;
    k = last_edge;
    while (edge_cnt < k + 4) begin
      if (edge_cnt == k + 3) chk("busy_before_fall", busy_o, 1);
      drive(1'b1, 1'b0, 77, 1'b0, 8'd0);
    end
    chk("busy_fall", busy_o, 0);
    acc_valid_i = 1'b0;
    acc_last_i  = 1'b0;
  endtask

  initial begin
    #2_000_000;
    $display("FAIL watchdog: simulation did not finish, got timeout, expected completion");
    $fatal(1);
  end

  initial begin
    int sh, chn, eff, cnt, n, acc, mode;

    tab[0]  = '{0, 100, 1'b0, 8'd6};
    tab[1]  = '{0, -50, 1'b0, 8'd0};
    tab[2]  = '{0, 5000, 1'b1, 8'd255};
    tab[3]  = '{1, 16, 1'b0, 8'd2};
    tab[4]  = '{1, 16, 1'b0, 8'd0};
    tab[5]  = '{1, 16, 1'b0, 8'd2};
    tab[6]  = '{1, 16, 1'b1, 8'd0};
    tab[7]  = '{2, 200, 1'b0, 8'd200};
    tab[8]  = '{2, 255, 1'b0, 8'd255};
    tab[9]  = '{2, 256, 1'b0, 8'd255};
    tab[10] = '{2, -1, 1'b1, 8'd0};
    for (int i = 0; i < 5; i++) tab[11 + i] = '{3, i + 1, (i == 4), 8'(i + 1)};
    for (int i = 0; i < 16; i++) bias_m[i] = 0;

    @(posedge clk); #1;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("reset_busy", busy_o, 0);
    chk("reset_valid", act_valid_o, 0);
    chk("reset_last", act_last_o, 0);
    chk("reset_result", act_result_o, 0);
    chk_en = 1'b1;

    for (int g = 0; g < 4; g++) begin
      case (g)
        0: begin
          // Sample offered alongside start in IDLE must be dropped.
          acc_valid_i = 1'b1; acc_data_i = 999;
          start(4, 1);
        end
        1: begin write_bias(0, 16); write_bias(1, -32); start(4, 2); end
        2: begin write_bias(0, 0); start(0, 1); end
        default: start(0, 1);
      endcase
      for (int i = 0; i < 16; i++)
        if (tab[i].grp == g) drive(1'b1, tab[i].last, tab[i].acc, 1'b1, tab[i].exp);
      end_layer();
    end

    // Config writes and start during RUN must be ignored.
    write_bias(0, 40); write_bias(1, 80); write_bias(2, 120); write_bias(3, 400);
    start(2, 4);
    drive(1'b1, 1'b0, 0, 1'b1, 8'd10);
    cfg_we_i = 1'b1; cfg_addr_i = 4'd3; cfg_bias_i = 9999;
    start_i = 1'b1; cfg_shift_i = 5'd0; cfg_ch_num_i = 5'd1;
    drive(1'b1, 1'b0, 0, 1'b1, 8'd20);
    cfg_we_i = 1'b0; start_i = 1'b0;
    drive(1'b1, 1'b0, 0, 1'b1, 8'd30);
    drive(1'b1, 1'b1, 0, 1'b1, 8'd100);
    end_layer();
    start(2, 4);
    drive(1'b1, 1'b0, 0, 1'b1, 8'd10);
    drive(1'b1, 1'b0, 0, 1'b1, 8'd20);
    drive(1'b1, 1'b0, 0, 1'b1, 8'd30);
    drive(1'b1, 1'b1, 0, 1'b1, 8'd100);
    end_layer();
    start(2, 0);
    drive(1'b1, 1'b0, 0, 1'b1, 8'd10);
    drive(1'b1, 1'b0, 0, 1'b1, 8'd10);
    drive(1'b1, 1'b1, 0, 1'b1, 8'd10);
    end_layer();

    // Mid-stream reset with two samples in flight.
    start(0, 16);
    drive(1'b1, 1'b0, 5, 1'b1, 8'd45);
    drive(1'b1, 1'b0, 5, 1'b1, 8'd85);
    chk_en = 1'b0;
    rst = 1'b0; acc_valid_i = 1'b0;
    @(posedge clk); #1;
    rst = 1'b1;
    chk("midrst_busy", busy_o, 0);
    chk("midrst_valid", act_valid_o, 0);
    chk("midrst_last", act_last_o, 0);
    chk("midrst_result", act_result_o, 0);
    exp_map.delete();
    last_res = 8'd0;
    for (int i = 0; i < 16; i++) bias_m[i] = 0;
    chk_en = 1'b1;
    for (int i = 0; i < 4; i++) drive(1'b0, 1'b0, 0, 1'b0, 8'd0);
    start(0, 16);
    for (int i = 0; i < 16; i++) drive(1'b1, (i == 15), 5, 1'b1, 8'd5);
    end_layer();

    // Randomized layers against the reference model.
    for (int l = 0; l < 3; l++) begin
      sh  = $urandom_range(0, 12);
      chn = $urandom_range(0, 31);
      for (int a = 0; a < 16; a++)
        write_bias(a, (a == 5 && l == 0) ? 32'h7fffffff : int'($urandom_range(0, 4000)) - 2000);
      eff = (chn == 0) ? 1 : ((chn > 16) ? 16 : chn);
      start(sh, chn);
      cnt = 0;
      n   = 40 + $urandom_range(0, 20);
      while (cnt < n) begin
        if ($urandom_range(0, 3) == 0) begin
          drive(1'b0, 1'($urandom_range(0, 1)), int'($urandom), 1'b0, 8'd0);
        end else begin
          mode = $urandom_range(0, 3);
          acc  = (mode == 0) ? int'($urandom) :
                 (mode == 1) ? 32'h7fffffff : int'($urandom_range(0, 8000)) - 2000;
          drive(1'b1, (cnt == n - 1), acc, 1'b1, ref_act(acc, bias_m[cnt % eff], sh));
          cnt++;
        end
      end
      end_layer();
    end

    for (int i = 0; i < 3; i++) drive(1'b0, 1'b0, 0, 1'b0, 8'd0);
    chk("scoreboard_drained", exp_map.num(), 0);
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
